keypad_encoder: RTL and testbench

//  Scans a 4x4 active-low matrix keypad, debounces it and encodes each press into the
//  (tipo, number) key code consumed by the calculator FSM. Sits between keypad pins and FSM.
//  One code per physical press, held HOLD_CYCLES clocks, then idle until key release.

---
 rtl/calc_keys_pkg.sv | 53 +++++
 rtl/row_sync.sv | 35 +++
 rtl/keypad_encoder.sv | 207 ++++++++++++++++++++
 tb/tb_keypad_encoder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/calc_keys_pkg.sv
// -----------------------------------------------------------------------------
// calc_keys_pkg
//   Key-code definitions shared by the keypad encoder and the calculator FSM
//   that decodes its output.
//   - key_code_t : (tipo, number) pair; tipo 0 = digit, 1 = command
//   - KEY_IDLE   : code driven when no key is being reported
//   - CMD_*      : command numbers carried with tipo = 1
//   - kp_state_t : encoder scan/debounce state encoding
//   - decode_row : classifies a synchronized row sample (exactly one low bit)
// -----------------------------------------------------------------------------
package calc_keys_pkg;

  typedef struct packed {
    logic       tipo;
    logic [3:0] number;
  } key_code_t;

  localparam logic [3:0] NUM_IDLE = 4'hF;
  localparam logic [3:0] CMD_ADD  = 4'b1010;
  localparam logic [3:0] CMD_SUB  = 4'b1011;
  localparam logic [3:0] CMD_EQ   = 4'b1100;
  localparam logic [3:0] CMD_CLR  = 4'b1111;

  localparam key_code_t KEY_IDLE = '{tipo: 1'b0, number: NUM_IDLE};

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DBNC     = 2'd1,
    EMIT     = 2'd2,
    WAIT_REL = 2'd3
  } kp_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } row_hit_t;

  // A sample names a key only when exactly one row is pulled low; no low rows
  // or several low rows (ghosting / multi-press) are both treated as no key.
  function automatic row_hit_t decode_row(input logic [3:0] rows);
    row_hit_t hit;
    hit = '{valid: 1'b0, idx: 2'd0};
    case (rows)
      4'b1110: hit = '{valid: 1'b1, idx: 2'd0};
      4'b1101: hit = '{valid: 1'b1, idx: 2'd1};
      4'b1011: hit = '{valid: 1'b1, idx: 2'd2};
      4'b0111: hit = '{valid: 1'b1, idx: 2'd3};
      default: hit = '{valid: 1'b0, idx: 2'd0};
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/row_sync.sv
// -----------------------------------------------------------------------------
// row_sync
//   Two-flop synchronizer for the asynchronous keypad row inputs. Both stages
//   reset to all ones, i.e. "no row pulled low".
//   Ports:
//     clk      in   system clock
//     reset    in   synchronous, active-high
//     async_i  in   raw row pins (active-low, pulled up)
//     sync_o   out  row value after two flops
// -----------------------------------------------------------------------------
module row_sync #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] async_i,
  output logic [Width-1:0] sync_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/keypad_encoder.sv
// -----------------------------------------------------------------------------
// keypad_encoder
//   Scans a 4x4 active-low matrix keypad, debounces presses and releases, and
//   emits one (tipo, number) key code per physical press, held for HOLD_CYCLES
//   clocks with a one-clock key_strobe on its first clock.
//   Parameters:
//     SCAN_DIV     clocks each column is driven before rows are sampled (>=3)
//     DEBOUNCE     identical consecutive samples for press and release (>=1)
//     HOLD_CYCLES  clocks a valid key code is held on tipo/number (>=1)
//   Ports:
//     clk         in   system clock
//     reset       in   synchronous, active-high
//     row[3:0]    in   keypad rows, active-low, asynchronous
//     col[3:0]    out  column drive, active-low, exactly one bit low
//     tipo        out  0 = digit, 1 = command
//     number[3:0] out  digit value or command code (4'hF when idle)
//     key_strobe  out  one-clock pulse on the first clock of each code
// -----------------------------------------------------------------------------
module keypad_encoder
  import calc_keys_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 4,
  parameter int unsigned DEBOUNCE    = 2,
  parameter int unsigned HOLD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       tipo,
  output logic [3:0] number,
  output logic       key_strobe
);

  localparam int unsigned DivW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW  = $clog2(DEBOUNCE + 1);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);

  localparam logic [DivW-1:0]  DivLast  = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0]  DbncLast = CntW'(DEBOUNCE);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES);

  // ---------------------------------------------------------------------------
  // Row synchronizer and sample classification
  // ---------------------------------------------------------------------------
  logic [3:0] row_s;

  row_sync #(
    .Width(4)
  ) u_row_sync (
    .clk    (clk),
    .reset  (reset),
    .async_i(row),
    .sync_o (row_s)
  );

  kp_state_t        state_q;
  logic [DivW-1:0]  div_q;
  logic [1:0]       c_q;
  logic [1:0]       r_q;
  logic [CntW-1:0]  cnt_q;
  logic [HoldW-1:0] hold_q;

  logic     sample_en;
  row_hit_t hit;
  logic     all_high;
  logic     confirm;

  // The dwell counter free-runs, so every state samples on the last clock of a
  // SCAN_DIV window. With the column frozen this gives a steady sample rate
  // for debounce and release; while scanning it also paces column rotation.
  // SCAN_DIV >= 3 leaves the synchronizer two clocks to settle after a move.
  assign sample_en = (div_q == DivLast);
  assign hit       = decode_row(row_s);
  assign all_high  = (row_s == 4'hF);

  // A press is confirmed on the sample that completes DEBOUNCE identical
  // samples. With DEBOUNCE == 1 the first valid sample in SCAN already counts.
  always_comb begin
    confirm = 1'b0;
    if (sample_en && hit.valid) begin
      if (state_q == SCAN) begin
        confirm = (DEBOUNCE == 1);
      end else if (state_q == DBNC) begin
        confirm = (hit.idx == r_q) && ((cnt_q + 1'b1) == DbncLast);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Key map: index k = 4*row + col. In both confirming cases hit.idx equals the
  // latched row, so the live sample and the driven column give the key.
  // ---------------------------------------------------------------------------
  logic [3:0] key_idx;
  logic       map_valid;
  key_code_t  map_code;

  assign key_idx = {hit.idx, c_q};

  always_comb begin
    map_valid = 1'b1;
    map_code  = KEY_IDLE;
    case (key_idx)
      4'd0:    map_code = '{tipo: 1'b0, number: 4'd1};
      4'd1:    map_code = '{tipo: 1'b0, number: 4'd2};
      4'd2:    map_code = '{tipo: 1'b0, number: 4'd3};
      4'd3:    map_code = '{tipo: 1'b1, number: CMD_ADD};
      4'd4:    map_code = '{tipo: 1'b0, number: 4'd4};
      4'd5:    map_code = '{tipo: 1'b0, number: 4'd5};
      4'd6:    map_code = '{tipo: 1'b0, number: 4'd6};
      4'd7:    map_code = '{tipo: 1'b1, number: CMD_SUB};
      4'd8:    map_code = '{tipo: 1'b0, number: 4'd7};
      4'd9:    map_code = '{tipo: 1'b0, number: 4'd8};
      4'd10:   map_code = '{tipo: 1'b0, number: 4'd9};
      4'd11:   map_code = '{tipo: 1'b1, number: CMD_EQ};
      4'd13:   map_code = '{tipo: 1'b0, number: 4'd0};
      4'd15:   map_code = '{tipo: 1'b1, number: CMD_CLR};
      // '*' (12) and '#' (14) carry no code.
      default: map_valid = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scan / debounce / emit / release FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SCAN;
      div_q      <= '0;
      c_q        <= 2'd0;
      r_q        <= 2'd0;
      cnt_q      <= '0;
      hold_q     <= '0;
      col        <= 4'b1110;
      tipo       <= KEY_IDLE.tipo;
      number     <= KEY_IDLE.number;
      key_strobe <= 1'b0;
    end else begin
      div_q      <= sample_en ? '0 : div_q + 1'b1;
      key_strobe <= 1'b0;

      case (state_q)
        SCAN, DBNC: begin
          if (confirm) begin
            cnt_q <= '0;
            if (map_valid) begin
              state_q    <= EMIT;
              tipo       <= map_code.tipo;
              number     <= map_code.number;
              key_strobe <= 1'b1;
              // First held clock is the one these assignments produce.
              hold_q     <= HoldW'(1);
            end else begin
              // Unmapped key: stay idle, but still wait for its release.
              state_q <= WAIT_REL;
            end
          end else if (sample_en) begin
            if (state_q == SCAN && hit.valid) begin
              state_q <= DBNC;
              r_q     <= hit.idx;
              cnt_q   <= CntW'(1);
            end else if (state_q == DBNC && hit.valid && hit.idx == r_q) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              // No key, or debounce broken: move on to the next column.
              state_q <= SCAN;
              cnt_q   <= '0;
              c_q     <= c_q + 2'd1;
              col     <= {col[2:0], col[3]};
            end
          end
        end

        EMIT: begin
          if (hold_q == HoldLast) begin
            state_q <= WAIT_REL;
            cnt_q   <= '0;
            tipo    <= KEY_IDLE.tipo;
            number  <= KEY_IDLE.number;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end

        WAIT_REL: begin
          if (sample_en) begin
            if (!all_high) begin
              cnt_q <= '0;
            end else if ((cnt_q + 1'b1) == DbncLast) begin
              state_q <= SCAN;
              cnt_q   <= '0;
              c_q     <= c_q + 2'd1;
              col     <= {col[2:0], col[3]};
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder (SCAN_DIV=4, DEBOUNCE=2, HOLD_CYCLES=3).
// The keypad is modelled as a switch matrix: row[r] is pulled low while key
// (r,c) is held and col[c] is driven low.
module tb_keypad_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        tipo;
  logic [3:0]  number;
  logic        key_strobe;
  logic [15:0] keys = '0;

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  keypad_encoder #(
    .SCAN_DIV   (4),
    .DEBOUNCE   (2),
    .HOLD_CYCLES(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .tipo      (tipo),
    .number    (number),
    .key_strobe(key_strobe)
  );

  // Output monitor on the falling edge: strobes, strobed codes, code run lengths.
  int         strobes = 0;
  int         run_cnt = 0;
  logic [4:0] codes[$];
  int         runs[$];

  always @(negedge clk) begin
    if (reset) begin
      run_cnt = 0;
    end else begin
      if (key_strobe) begin
        strobes++;
        codes.push_back({tipo, number});
      end
      if (tipo || number != 4'hF) begin
        run_cnt++;
      end else if (run_cnt > 0) begin
        runs.push_back(run_cnt);
        run_cnt = 0;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; inputs are driven and outputs sampled 2 units after posedge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_col(input logic [3:0] target, input int limit, output bit found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      if (col == target) found = 1'b1;
      else tick(1);
    end
  endtask

  int s0, c0, r0, n;
  bit found;

  initial begin
    // 1: reset and free scanning
    reset = 1'b1;
    tick(3);
    check("t1 reset col", col, 4'b1110);
    check("t1 reset tipo", tipo, 1'b0);
    check("t1 reset number", number, 4'hF);
    check("t1 reset strobe", key_strobe, 1'b0);
    reset = 1'b0;
    n = 0;
    while (col == 4'b1110 && n < 20) begin tick(1); n++; end
    check("t1 dwell c0", n, 4);
    check("t1 col c1", col, 4'b1101);
    n = 0;
    while (col == 4'b1101 && n < 20) begin tick(1); n++; end
    check("t1 dwell c1", n, 4);
    check("t1 col c2", col, 4'b1011);

    // 2: key '5' held long, then released
    s0 = strobes; c0 = codes.size(); r0 = runs.size();
    keys[5] = 1'b1;
    tick(200);
    check("t2 col frozen", col, 4'b1101);
    keys = '0;
    n = 0;
    while (col == 4'b1101 && n < 60) begin tick(1); n++; end
    check("t2 resume col", col, 4'b1011);
    tick(10);
    check("t2 strobes", strobes - s0, 1);
    if (codes.size() > c0) check("t2 code", codes[c0], 5'h05);
    if (runs.size() > r0) check("t2 hold len", runs[r0], 3);
    check("t2 runs", runs.size() - r0, 1);
    check("t2 idle number", number, 4'hF);

    // 3: commands A, C, D
    s0 = strobes; c0 = codes.size(); r0 = runs.size();
    keys[3] = 1'b1;  tick(40); keys = '0; tick(30);
    keys[11] = 1'b1; tick(40); keys = '0; tick(30);
    keys[15] = 1'b1; tick(40); keys = '0; tick(30);
    check("t3 strobes", strobes - s0, 3);
    if (codes.size() > c0 + 2) begin
      check("t3 code A", codes[c0], 5'h1A);
      check("t3 code C", codes[c0+1], 5'h1C);
      check("t3 code D", codes[c0+2], 5'h1F);
    end
    if (runs.size() > r0 + 2) check("t3 hold len D", runs[r0+2], 3);

    // 4: bounce on '0' (r3,c1) for one sample, then a stable press
    s0 = strobes; c0 = codes.size();
    wait_col(4'b1110, 40, found);
    check("t4 reach c0", found, 1'b1);
    wait_col(4'b1101, 40, found);
    check("t4 reach c1", found, 1'b1);
    keys[13] = 1'b1;
    tick(4);
    keys = '0;
    tick(30);
    check("t4 bounce strobes", strobes - s0, 0);
    keys[13] = 1'b1; tick(60); keys = '0; tick(30);
    check("t4 strobes", strobes - s0, 1);
    if (codes.size() > c0) check("t4 code 0", codes[c0], 5'h00);

    // 5: '1'+'4' together (two rows low), then '*'
    s0 = strobes; r0 = runs.size();
    keys[0] = 1'b1; keys[4] = 1'b1; tick(60); keys = '0; tick(30);
    check("t5 dual strobes", strobes - s0, 0);
    keys[12] = 1'b1; tick(60); keys = '0; tick(30);
    check("t5 star strobes", strobes - s0, 0);
    check("t5 no codes", runs.size() - r0, 0);

    // 6: reset during EMIT of '7' (r2,c0), key still held
    keys[8] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (key_strobe) found = 1'b1;
      else tick(1);
    end
    check("t6 strobe seen", found, 1'b1);
    reset = 1'b1;
    tick(1);
    check("t6 rst tipo", tipo, 1'b0);
    check("t6 rst number", number, 4'hF);
    check("t6 rst strobe", key_strobe, 1'b0);
    check("t6 rst col", col, 4'b1110);
    reset = 1'b0;
    s0 = strobes; c0 = codes.size();
    tick(80);
    check("t6 reemit strobes", strobes - s0, 1);
    if (codes.size() > c0) check("t6 code 7", codes[c0], 5'h07);
    keys = '0;
    tick(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
